// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with valid/ready on both sides.
// Accepts one WIDTH-bit word per load handshake and shifts it out one bit per
// accepted serial beat. frame_start/frame_last mark the first and last bits.
// A new word can load on the edge that accepts the last bit, so frames stream
// back-to-back with no idle cycle.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   parallel_in   word to serialize, sampled on load handshake
//   load_valid    upstream word available
//   load_ready    serializer can take a word this cycle (combinational)
//   serial_out    current serial bit
//   serial_valid  serial_out carries a valid bit
//   serial_ready  downstream accepts the current bit
//   frame_start   first bit of a word is presented
//   frame_last    last bit of a word is presented
//   busy          a word is being shifted
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             at_last;

    assign at_last = (cnt == CNT_LAST);

    // State, shift register and bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        cnt_nxt      = cnt;
        load_ready   = 1'b0;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        frame_start  = 1'b0;
        frame_last   = 1'b0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    sreg_nxt  = parallel_in;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                busy         = 1'b1;
                serial_valid = 1'b1;
                serial_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
                frame_start  = (cnt == '0);
                frame_last   = at_last;
                // Accept the next word only on the edge that retires the last bit
                load_ready   = at_last && serial_ready;

                if (serial_ready) begin
                    if (at_last) begin
                        if (load_valid) begin
                            sreg_nxt = parallel_in;
                            cnt_nxt  = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        // Shift toward the output end, zero fill behind
                        if (MSB_FIRST) begin
                            sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                        end else begin
                            sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
                        end
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer that sits directly downstream of the parallel-in parallel-out register stage. It accepts one parallel word per valid/ready handshake and shifts it out one bit per clock, framed with start and last markers. The serial side has its own valid/ready handshake and supports backpressure. Back-to-back words stream with no idle cycle between frames.

## Interface
- WIDTH, 4: word width in bits; legal range 2 to 32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- parallel_in  input  WIDTH  word to serialize; sampled only on load handshake.
- load_valid  input  1  upstream has a word on parallel_in.
- load_ready  output  1  serializer can accept a word this cycle.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a valid bit.
- serial_ready  input  1  downstream accepts the current bit.
- frame_start  output  1  high while the first bit of a word is presented.
- frame_last  output  1  high while the last bit of a word is presented.
- busy  output  1  a word is being shifted (state SHIFT).

## Operation
- States: IDLE, SHIFT. Internal shift register `sreg[WIDTH-1:0]` and bit counter `cnt` of width clog2(WIDTH).
- Load handshake: a word is accepted at the rising edge where load_valid && load_ready.
- Serial handshake: a bit is accepted at the rising edge where serial_valid && serial_ready.
- load_ready (combinational) = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && serial_ready).
- IDLE:
  - On a load, capture parallel_in into sreg, set cnt=0 and go to SHIFT.
  - Otherwise hold.
- SHIFT, presenting a bit:
  - serial_valid=1.
  - serial_out = sreg[WIDTH-1] when MSB_FIRST, else sreg[0].
  - frame_start = (cnt==0).
  - frame_last = (cnt==WIDTH-1).
- SHIFT, bit accepted, not last: shift sreg toward the output end (zero fill) and increment cnt.
- SHIFT, bit accepted, last:
  - If load_valid: reload sreg from parallel_in, set cnt=0 and stay in SHIFT.
  - Otherwise go to IDLE.
- SHIFT, serial_ready low: sreg, cnt, serial_out and the frame flags all hold. load_ready stays low.
- Outside SHIFT: serial_valid=0, serial_out=0, frame_start=0, frame_last=0.
- busy = (state==SHIFT).

## Timing
- Reset (rst low, asynchronous): state=IDLE, sreg=0, cnt=0, serial_valid=0, serial_out=0, frame_start=0, frame_last=0, busy=0.
  - load_ready reads 1 during reset, but no load is captured while rst is low.
- Deassertion: the first load can be accepted at the first rising edge with rst high.
- Latency: a word loaded at edge N has its first bit valid in the cycle after edge N.
  - With serial_ready held high, the last bit is presented in cycle N+WIDTH.
- Throughput: one bit per cycle. With load_valid held, a new word loads on the same edge that accepts the previous word's last bit, so there is no bubble.
- Reset mid-frame: the partial word is discarded and outputs return to reset values immediately. The word is not resumed.
- load_valid while busy and not on an accepted last bit: ignored (load_ready=0). Upstream must hold parallel_in and load_valid until accepted.
- parallel_in changes while not loading have no effect.

## Test plan
- Reset then load 4'b1101 with MSB_FIRST=1 and serial_ready=1:
  - serial_out = 1,1,0,1 in the 4 cycles after the load edge.
  - frame_start on bit 1, frame_last on bit 4.
  - busy and serial_valid drop in the cycle after.
- Back-to-back: load_valid held with 4'b1101 then 4'b1010 -> 8 consecutive valid bits 1,1,0,1,1,0,1,0; the second load_ready pulse coincides with the first frame's last bit.
- Backpressure: load 4'b0111 and drop serial_ready for 2 cycles while bit 2 is presented -> bit 2 (1) holds with serial_valid=1; the frame completes in 6 cycles with sequence 0,1,1,1.
- LSB-first build (MSB_FIRST=0): load 4'b1101 -> serial_out 1,0,1,1.
- Reset mid-operation: assert rst low after bit 2 of 4'b1010 -> serial_valid=0, busy=0, serial_out=0 immediately. After release, load 4'b0110 -> clean sequence 0,1,1,0.
- Load while busy: raise load_valid with 4'b0111 during bit 1 of 4'b1101 -> load_ready stays low until bit 4; 0111 loads then and streams with no gap.
